// File: rtl/axis_pair_packer.sv
// Packs consecutive DATA_WIDTH-bit AXI-Stream samples into {second, first} words of 2*DATA_WIDTH.
// A packet that ends on a low sample is closed with PAD_VALUE in the high half.
module axis_pair_packer #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = {DATA_WIDTH{1'b0}}
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic [2*DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tvalid,
  output logic                    m_tlast,
  input  logic                    m_tready
);

  logic                    have_low_r;
  logic [DATA_WIDTH-1:0]   low_r;

  logic                    in_xfer_s;
  logic                    out_xfer_s;
  logic                    load_s;
  logic [2*DATA_WIDTH-1:0] word_s;
  logic                    word_last_s;
  logic                    have_low_nxt_s;
  logic [DATA_WIDTH-1:0]   low_nxt_s;
  logic                    m_tvalid_nxt_s;

  // Upstream may push whenever the output register is free or draining this cycle.
  assign s_tready   = !m_tvalid || m_tready;
  assign in_xfer_s  = s_tvalid && s_tready;
  assign out_xfer_s = m_tvalid && m_tready;

  // Pairing decision and next-state computation.
  always_comb begin
    load_s         = 1'b0;
    word_s         = m_tdata;
    word_last_s    = m_tlast;
    have_low_nxt_s = have_low_r;
    low_nxt_s      = low_r;
    m_tvalid_nxt_s = m_tvalid;

    if (in_xfer_s) begin
      if (have_low_r) begin
        load_s         = 1'b1;
        word_s         = {s_tdata, low_r};
        word_last_s    = s_tlast;
        have_low_nxt_s = 1'b0;
      end else if (s_tlast) begin
        // Lone sample ends the packet: pad so no pair spans two packets.
        load_s         = 1'b1;
        word_s         = {PAD_VALUE, s_tdata};
        word_last_s    = 1'b1;
      end else begin
        low_nxt_s      = s_tdata;
        have_low_nxt_s = 1'b1;
      end
    end else begin
      have_low_nxt_s = have_low_r;
    end

    if (load_s) begin
      m_tvalid_nxt_s = 1'b1;
    end else if (out_xfer_s) begin
      m_tvalid_nxt_s = 1'b0;
    end else begin
      m_tvalid_nxt_s = m_tvalid;
    end
  end

  // Pairing state and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      have_low_r <= 1'b0;
      low_r      <= {DATA_WIDTH{1'b0}};
      m_tdata    <= {(2*DATA_WIDTH){1'b0}};
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
    end else begin
      have_low_r <= have_low_nxt_s;
      low_r      <= low_nxt_s;
      m_tvalid   <= m_tvalid_nxt_s;
      m_tdata    <= word_s;
      m_tlast    <= word_last_s;
    end
  end

endmodule

// File: tb/tb_axis_pair_packer.sv
// Scoreboard bench for axis_pair_packer: a sample-level pairing model feeds an expected-word
// queue; a negedge monitor pops and compares on every output transfer.
module tb_axis_pair_packer;
  localparam int unsigned DW  = 8;
  localparam logic [DW-1:0] PAD = 8'h00;

  logic            clock;
  logic            reset;
  logic [DW-1:0]   s_tdata;
  logic            s_tvalid;
  logic            s_tlast;
  logic            s_tready;
  logic [2*DW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;

  int checks;
  int errors;

  logic [DW-1:0]   pend_q[$];
  logic [2*DW:0]   exp_q[$];

  axis_pair_packer #(.DATA_WIDTH(DW), .PAD_VALUE(PAD)) dut (
    .clock   (clock),
    .reset   (reset),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_tready(m_tready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect samples, emit a word once two are held or the packet ends.
  task automatic model_accept(input logic [DW-1:0] d, input logic l);
    pend_q.push_back(d);
    if (pend_q.size() == 2) begin
      exp_q.push_back({l, pend_q[1], pend_q[0]});
      pend_q.delete();
    end else if (l) begin
      exp_q.push_back({1'b1, PAD, pend_q[0]});
      pend_q.delete();
    end
  endtask

  // Monitor: handshakes seen at negedge complete on the following rising edge.
  always @(negedge clock) begin
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tlast);
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {15'd0, m_tlast, m_tdata}, 32'hFFFF_FFFF);
        end else begin
          logic [2*DW:0] e;
          e = exp_q.pop_front();
          chk("word", {15'd0, m_tlast, m_tdata}, {15'd0, e});
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    @(negedge clock);
    while (!s_tready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  bit rnd_done;

  initial begin
    checks = 0; errors = 0; rnd_done = 1'b0;
    reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    idle(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("reset_m_tlast",  {31'd0, m_tlast}, 32'd0);
    chk("reset_m_tdata",  {16'd0, m_tdata}, 32'd0);
    chk("reset_s_tready", {31'd0, s_tready}, 32'd1);
    @(posedge clock); #1;

    // Pairing with one-cycle latency after the second sample
    send(8'h11, 1'b0);
    chk("pair1_not_early", {31'd0, m_tvalid}, 32'd0);
    send(8'h22, 1'b0);
    chk("pair1_latency", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, 16'h2211});
    send(8'h33, 1'b0);
    chk("pair_drained", {31'd0, m_tvalid}, 32'd0);
    send(8'h44, 1'b0);
    chk("pair2_latency", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, 16'h4433});
    idle(2);

    // Odd packet padded, next packet starts on a fresh pair
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    chk("odd_first", {15'd0, m_tlast, m_tdata}, {15'd0, 1'b0, 16'hA2A1});
    send(8'hA3, 1'b1);
    chk("odd_pad", {15'd0, m_tlast, m_tdata}, {15'd0, 1'b1, 16'h00A3});
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    chk("after_odd", {15'd0, m_tlast, m_tdata}, {15'd0, 1'b0, 16'hB2B1});
    idle(2);

    // Simultaneous drain and load keeps m_tvalid high
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b1);
    chk("no_bubble", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, 16'h00C3});
    idle(2);

    // Backpressure: pending word held stable, input stalled
    m_tready = 1'b0;
    send(8'hD1, 1'b0);
    send(8'hD2, 1'b0);
    s_tvalid = 1'b1; s_tdata = 8'hD3; s_tlast = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("bp_s_tready", {31'd0, s_tready}, 32'd0);
      chk("bp_hold", {14'd0, m_tvalid, m_tlast, m_tdata}, {14'd0, 1'b1, 1'b0, 16'hD2D1});
    end
    @(posedge clock); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1;
    idle(3);
    chk("bp_once", exp_q.size(), 32'd0);
    chk("bp_drained", {31'd0, m_tvalid}, 32'd0);

    // Reset mid-pair discards the held low sample
    send(8'h55, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("reset_mid_valid", {31'd0, m_tvalid}, 32'd0);
    reset = 1'b0;
    send(8'h66, 1'b0);
    send(8'h77, 1'b0);
    chk("reset_mid_pair", {15'd0, m_tvalid, m_tdata}, {15'd0, 1'b1, 16'h7766});
    idle(2);

    // Random traffic against the scoreboard
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          idle($urandom_range(0, 2));
          send(DW'($urandom), (i == 999) ? 1'b1 : ($urandom_range(0, 5) == 0));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    m_tready = 1'b1;
    for (int i = 0; i < 50 && (exp_q.size() != 0 || m_tvalid); i++) idle(1);
    chk("final_exp_empty", exp_q.size(), 32'd0);
    chk("final_valid_low", {31'd0, m_tvalid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
